cla_adder: RTL and testbench
============================

Name: cla_adder

Overview:
- Registered carry-lookahead adder for the post-quantum arithmetic datapath (Kyber coefficient domain, q = 3329).
- Adds two DATA_WID-bit unsigned operands plus a carry-in.
- Delivers a full-width DATA_WID+1-bit sum from an output register, one clock after capture.
- Carries are computed by 4-bit lookahead blocks combined through a second-level group lookahead unit, not by a ripple chain.

Parameters:
- DATA_WID, 12, operand width in bits; must be a positive multiple of BLOCK_WID, otherwise an elaboration-time $error is raised.
- BLOCK_WID, 4, width of each first-level lookahead block.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- in1  input  DATA_WID  unsigned operand A
- in2  input  DATA_WID  unsigned operand B
- carry_in  input  1  carry into bit 0
- out_valid  output  1  sum holds a new result
- sum  output  DATA_WID+1  {carry_out, sum bits}; MSB is the final carry

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous deassert at the system level): sum = 0, out_valid = 0. Reset mid-operation discards any in-flight result.
- Bit-level terms: g[i] = in1[i] & in2[i]; p[i] = in1[i] ^ in2[i].
- Each block computes its internal carries in lookahead form from its block carry-in. It exports group generate GG and group propagate GP.
- Block carry-ins: c[0] = carry_in; c[k+1] = GG[k] | (GP[k] & c[k]). These are expanded in lookahead (sum-of-products) form across all blocks.
- Sum bits: p[i] ^ carry-into-bit-i.
- sum[DATA_WID] is the carry out of the top block.
- Arithmetic: sum = in1 + in2 + carry_in, exact, unsigned, never truncated. Maximum is 2*(2^DATA_WID - 1) + 1 = 8191 at default width.
- Latency 1: on each rising clk, sum loads the combinational result when in_valid = 1, otherwise sum holds its value.
- out_valid <= in_valid every cycle.
- No backpressure. A new operand pair is accepted every cycle.
- X/undefined inputs while in_valid = 0 must not disturb sum.

Optional Feature:
- Macro CLA_ADDER_IN_REG_EN.
- Defined: adds an input register stage for in1, in2, carry_in and in_valid, all reset to 0. Latency becomes 2 cycles and out_valid follows in_valid by 2 cycles. This supports timing closure at high clock rates.
- Undefined: latency 1 as described above.
- The arithmetic result is identical in both builds.

Decomposition:
- Package cla_pkg holds: DATA_WID_DEFAULT = 12, BLOCK_WID = 4, KYBER_Q = 3329, and typedef coeff_t = logic [DATA_WID_DEFAULT-1:0].
- Sub-module cla_block4 (one natural sub-module):
  - inputs: 4-bit a, 4-bit b, cin
  - outputs: 4-bit s, gg, gp
  - instantiated DATA_WID/BLOCK_WID times by a generate loop
- The group lookahead logic and the output register stay in cla_adder.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> sum = 0, out_valid = 0. Assert rst_n asynchronously mid-stream -> outputs clear immediately, without waiting for a clock edge.
- Basic sequence (in_valid = 1, carry_in = 0) -> each result appears one cycle later:
  - 0+0 -> 0
  - 10+0 -> 10
  - 20+0 -> 20
  - 20+10 -> 30
  - 20+20 -> 40
  - 256+0 -> 256
- Kyber-range overflow: 3329+3329 -> 6658 (0x1A02), with sum[12] = 1.
- Full carry propagation: 4095+0 with carry_in = 1 -> 4096. Then 4095+4095 with carry_in = 1 -> 8191.
- Hold behaviour: result 40 latched, then in_valid = 0 with in1 = 4095 -> sum stays 40 and out_valid falls one cycle after in_valid.
- Randomized: 10,000 vectors, back-to-back with random in_valid, checked against a reference model in1 + in2 + carry_in. Repeat with CLA_ADDER_IN_REG_EN defined, checking 2-cycle latency.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and types for the Kyber-domain carry-lookahead adder.
`default_nettype none

// +------------------------------------------------------------------+
// | Module      : cla_pkg                                            |
// | Description : Widths, Kyber modulus and coefficient type used by |
// |               cla_adder and its lookahead block.                 |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package cla_pkg;

  localparam int DATA_WID_DEFAULT = 12;
  localparam int BLOCK_WID        = 4;
  localparam int KYBER_Q          = 3329;

  typedef logic [DATA_WID_DEFAULT-1:0] coeff_t;

endpackage

`default_nettype wire

// File: rtl/cla_block4.sv
// 4-bit carry-lookahead block: sum bits from a block carry-in, plus group
// generate/propagate terms that do not depend on that carry-in.
`default_nettype none

// +------------------------------------------------------------------+
// | Module      : cla_block4                                         |
// | Description : First-level 4-bit lookahead block.                 |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module cla_block4
  import cla_pkg::*;
(
  input  logic [BLOCK_WID-1:0] a,
  input  logic [BLOCK_WID-1:0] b,
  input  logic                 cin,
  output logic [BLOCK_WID-1:0] s,
  output logic                 gg,
  output logic                 gp
);

  logic [BLOCK_WID-1:0] g_w;
  logic [BLOCK_WID-1:0] p_w;
  logic [BLOCK_WID-1:0] c_w;

  assign g_w = a & b;
  assign p_w = a ^ b;

  // Internal carries in flattened sum-of-products form.
  assign c_w[0] = cin;
  assign c_w[1] = g_w[0] | (p_w[0] & cin);
  assign c_w[2] = g_w[1] | (p_w[1] & g_w[0]) | (p_w[1] & p_w[0] & cin);
  assign c_w[3] = g_w[2] | (p_w[2] & g_w[1]) | (p_w[2] & p_w[1] & g_w[0])
                | (p_w[2] & p_w[1] & p_w[0] & cin);

  assign s  = p_w ^ c_w;
  assign gg = g_w[3] | (p_w[3] & g_w[2]) | (p_w[3] & p_w[2] & g_w[1])
            | (p_w[3] & p_w[2] & p_w[1] & g_w[0]);
  assign gp = &p_w;

endmodule

`default_nettype wire

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder, sum = in1 + in2 + carry_in.
// Optional input register stage via CLA_ADDER_IN_REG_EN (latency 1 -> 2).
`default_nettype none

// +------------------------------------------------------------------+
// | Module      : cla_adder                                          |
// | Description : Registered CLA adder built from 4-bit lookahead    |
// |               blocks and a group lookahead unit.                 |
// |               Macro CLA_ADDER_IN_REG_EN adds an input stage.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module cla_adder
  import cla_pkg::*;
#(
  parameter int DATA_WID  = DATA_WID_DEFAULT,
  parameter int BLOCK_WID = cla_pkg::BLOCK_WID
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [DATA_WID-1:0] in1,
  input  logic [DATA_WID-1:0] in2,
  input  logic                carry_in,
  output logic                out_valid,
  output logic [DATA_WID:0]   sum
);

  localparam int NBLK = (DATA_WID / BLOCK_WID > 0) ? DATA_WID / BLOCK_WID : 1;

  if ((DATA_WID <= 0) || (DATA_WID % BLOCK_WID != 0)) begin : g_bad_wid
    $error("cla_adder: DATA_WID (%0d) must be a positive multiple of BLOCK_WID (%0d)",
           DATA_WID, BLOCK_WID);
  end

  if (BLOCK_WID != cla_pkg::BLOCK_WID) begin : g_bad_blk
    $error("cla_adder: BLOCK_WID (%0d) must match the lookahead block width (%0d)",
           BLOCK_WID, cla_pkg::BLOCK_WID);
  end

  logic [DATA_WID-1:0] op_a_w;
  logic [DATA_WID-1:0] op_b_w;
  logic                op_ci_w;
  logic                op_valid_w;

`ifdef CLA_ADDER_IN_REG_EN
  logic [DATA_WID-1:0] in1_q;
  logic [DATA_WID-1:0] in2_q;
  logic                carry_in_q;
  logic                in_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in1_q      <= '0;
      in2_q      <= '0;
      carry_in_q <= 1'b0;
      in_valid_q <= 1'b0;
    end else begin
      in1_q      <= in1;
      in2_q      <= in2;
      carry_in_q <= carry_in;
      in_valid_q <= in_valid;
    end
  end

  assign op_a_w     = in1_q;
  assign op_b_w     = in2_q;
  assign op_ci_w    = carry_in_q;
  assign op_valid_w = in_valid_q;
`else
  assign op_a_w     = in1;
  assign op_b_w     = in2;
  assign op_ci_w    = carry_in;
  assign op_valid_w = in_valid;
`endif

  logic [NBLK-1:0]     gg_w;
  logic [NBLK-1:0]     gp_w;
  logic [NBLK:0]       bc_w;
  logic [DATA_WID-1:0] s_w;

  // Carry into block k, expanded as OR of (GG[j] & GP[j+1..k-1]) plus the
  // carry_in term, so no block waits on its neighbour's carry.
  function automatic logic block_carry(input int k,
                                       input logic [NBLK-1:0] g,
                                       input logic [NBLK-1:0] p,
                                       input logic ci);
    logic acc;
    logic prod;
    acc = 1'b0;
    for (int j = 0; j < NBLK; j++) begin
      if (j < k) begin
        prod = g[j];
        for (int m = j + 1; m < NBLK; m++) begin
          if (m < k) prod = prod & p[m];
        end
        acc = acc | prod;
      end
    end
    prod = ci;
    for (int m = 0; m < NBLK; m++) begin
      if (m < k) prod = prod & p[m];
    end
    return acc | prod;
  endfunction

  for (genvar k = 0; k <= NBLK; k++) begin : g_carry
    assign bc_w[k] = block_carry(k, gg_w, gp_w, op_ci_w);
  end

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    cla_block4 u_blk (
      .a   (op_a_w[k*BLOCK_WID +: BLOCK_WID]),
      .b   (op_b_w[k*BLOCK_WID +: BLOCK_WID]),
      .cin (bc_w[k]),
      .s   (s_w[k*BLOCK_WID +: BLOCK_WID]),
      .gg  (gg_w[k]),
      .gp  (gp_w[k])
    );
  end

  logic [DATA_WID:0] sum_d;
  logic [DATA_WID:0] sum_q;
  logic              out_valid_q;

  assign sum_d = op_valid_w ? {bc_w[NBLK], s_w} : sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      out_valid_q <= op_valid_w;
    end
  end

  assign sum       = sum_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder: directed steps then random traffic,
// results scored against a queue of bench-computed sums.
`default_nettype none

// +------------------------------------------------------------------+
// | Module      : tb_cla_adder                                       |
// | Description : Scoreboard bench for cla_adder (both builds).      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_cla_adder;
  import cla_pkg::*;

  localparam int W = DATA_WID_DEFAULT;
`ifdef CLA_ADDER_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  coeff_t       in1;
  coeff_t       in2;
  logic         carry_in;
  logic         out_valid;
  logic [W:0]   sum;

  cla_adder #(.DATA_WID(W), .BLOCK_WID(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [W:0] exp_q[$];
  logic [W:0] model_sum = '0;
  logic [1:0] vpipe     = 2'b00;

  task automatic check_eq(input string tag, input logic [W:0] obs, input logic [W:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: scores what the DUT registered so far.
  task automatic check_outputs();
    logic exp_v;
    exp_v = (LAT == 1) ? vpipe[0] : vpipe[1];
    check_eq("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, exp_v});
    if (exp_v) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL sb_empty: observed 0 entries expected at least 1");
      end else begin
        model_sum = exp_q.pop_front();
      end
    end
    check_eq("sum", sum, model_sum);
  endtask

  task automatic drive(input logic v, input coeff_t a, input coeff_t b, input logic ci);
    logic [W:0] e;
    @(negedge clk);
    check_outputs();
    in_valid = v;
    in1      = a;
    in2      = b;
    carry_in = ci;
    if (v) begin
      e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      exp_q.push_back(e);
    end
    vpipe = {vpipe[0], v};
  endtask

  task automatic clear_model();
    exp_q.delete();
    model_sum = '0;
    vpipe     = 2'b00;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in1      = coeff_t'($urandom);
    in2      = coeff_t'($urandom);
    carry_in = 1'b1;

    // Reset held with live-looking random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_sum", sum, '0);
      check_eq("rst_valid", {{W{1'b0}}, out_valid}, '0);
      in1 = coeff_t'($urandom);
      in2 = coeff_t'($urandom);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    clear_model();

    drive(1'b1, 12'd0,   12'd0,  1'b0);
    drive(1'b1, 12'd10,  12'd0,  1'b0);
    drive(1'b1, 12'd20,  12'd0,  1'b0);
    drive(1'b1, 12'd20,  12'd10, 1'b0);
    drive(1'b1, 12'd20,  12'd20, 1'b0);
    drive(1'b1, 12'd256, 12'd0,  1'b0);
    drive(1'b1, coeff_t'(KYBER_Q), coeff_t'(KYBER_Q), 1'b0);
    drive(1'b1, 12'd4095, 12'd0,    1'b1);
    drive(1'b1, 12'd4095, 12'd4095, 1'b1);

    // Hold: 40 latched, then idle cycles with noisy operands.
    drive(1'b1, 12'd20,   12'd20,   1'b0);
    drive(1'b0, 12'd4095, 12'd0,    1'b0);
    drive(1'b0, 12'd4095, 12'd4095, 1'b1);
    drive(1'b0, 12'd4095, 12'd1,    1'b1);
    drive(1'b0, 12'd0,    12'd0,    1'b0);

    // Asynchronous reset in the middle of traffic, away from any clock edge.
    drive(1'b1, 12'd100, 12'd200, 1'b0);
    drive(1'b1, 12'd5,   12'd6,   1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_sum", sum, '0);
    check_eq("async_rst_valid", {{W{1'b0}}, out_valid}, '0);
    @(negedge clk);
    check_eq("async_hold_sum", sum, '0);
    check_eq("async_hold_valid", {{W{1'b0}}, out_valid}, '0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    clear_model();

    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), coeff_t'($urandom), coeff_t'($urandom),
            1'($urandom));
    end

    for (int i = 0; i < LAT + 2; i++) begin
      drive(1'b0, coeff_t'($urandom), coeff_t'($urandom), 1'($urandom));
    end
    check_eq("sb_drained", (W+1)'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
